// File: rtl/reg_scoreboard_pkg.sv
// Shared constants and types for the integer-register write scoreboard.
package reg_scoreboard_pkg;
  localparam int SB_NREG   = 32;
  localparam int SB_REG_AW = 5;
  localparam int SB_CW     = 2;

  localparam logic [1:0] SB_IDLE  = 2'd0;
  localparam logic [1:0] SB_DRAIN = 2'd1;
  localparam logic [1:0] SB_DONE  = 2'd2;

  typedef logic [SB_REG_AW-1:0] reg_idx_t;
endpackage

// File: rtl/reg_scoreboard_if.sv
// Decode-issue and writeback signals shared between the decode stage and the scoreboard.
interface reg_scoreboard_if;
  import reg_scoreboard_pkg::*;

  logic     D_valid_i;
  reg_idx_t D_rs1_i;
  logic     D_use_rs1_i;
  reg_idx_t D_rs2_i;
  logic     D_use_rs2_i;
  logic     D_need_dstE_i;
  reg_idx_t D_dstE_i;
  logic     MD_need_dstE_i;
  reg_idx_t MD_dstE_i;
  logic     D_stall_o;
  logic     D_issue_o;

  modport master (
    output D_valid_i, D_rs1_i, D_use_rs1_i, D_rs2_i, D_use_rs2_i,
    output D_need_dstE_i, D_dstE_i, MD_need_dstE_i, MD_dstE_i,
    input  D_stall_o, D_issue_o
  );

  modport slave (
    input  D_valid_i, D_rs1_i, D_use_rs1_i, D_rs2_i, D_use_rs2_i,
    input  D_need_dstE_i, D_dstE_i, MD_need_dstE_i, MD_dstE_i,
    output D_stall_o, D_issue_o
  );
endinterface

// File: rtl/reg_scoreboard_sb_counter.sv
// Per-register pending-writer counter; a decrement at zero is reported, not applied.
module sb_counter #(
  parameter int CW = 2
) (
  input  logic          clk_i,
  input  logic          rst,
  input  logic          inc,
  input  logic          dec,
  input  logic          clr,
  output logic [CW-1:0] cnt,
  output logic          nz,
  output logic          sat,
  output logic          underflow
);
  logic dec_ok;

  assign nz        = (cnt != '0);
  assign sat       = (cnt == {CW{1'b1}});
  assign dec_ok    = dec & nz;
  // A flush squashes the writeback too, so it cannot raise an error
  assign underflow = dec & ~nz & ~clr;

  always_ff @(posedge clk_i) begin
    if (rst || clr) begin
      cnt <= '0;
    end else if (inc && !dec_ok) begin
      cnt <= cnt + CW'(1);
    end else if (dec_ok && !inc) begin
      cnt <= cnt - CW'(1);
    end
  end
endmodule

// File: rtl/reg_scoreboard.sv
// Register write scoreboard: RAW/saturation issue hold plus a drain FSM for serialising instructions.
module reg_scoreboard
  import reg_scoreboard_pkg::*;
#(
  parameter int NREG = SB_NREG,
  parameter int CW   = SB_CW
) (
  input  logic                  clk_i,
  input  logic                  rst,
  reg_scoreboard_if.slave       sb,
  input  logic                  flush_i,
  input  logic                  drain_req_i,
  output logic                  drain_done_o,
  output logic [NREG-1:0]       busy_o,
  output logic                  sb_err_o
);
  logic [NREG-1:0][CW-1:0] cnt_all;
  logic [NREG-1:0]         nz_v;
  logic [NREG-1:0]         sat_v;
  logic [NREG-1:0]         uf_v;
  logic [1:0]              state;
  logic                    raw;
  logic                    sat_hit;
  logic                    all_zero;
  logic                    stall;
  logic                    issue;
  logic                    sb_err_q;

  // x0 is hardwired idle: never busy, never saturated, writeback ignored
  assign cnt_all[0] = '0;
  assign nz_v[0]    = 1'b0;
  assign sat_v[0]   = 1'b0;
  assign uf_v[0]    = 1'b0;

  for (genvar r = 1; r < NREG; r++) begin : g_cnt
    sb_counter #(.CW(CW)) u_cnt (
      .clk_i     (clk_i),
      .rst       (rst),
      .inc       (issue & sb.D_need_dstE_i & (sb.D_dstE_i == SB_REG_AW'(r))),
      .dec       (sb.MD_need_dstE_i & (sb.MD_dstE_i == SB_REG_AW'(r))),
      .clr       (flush_i),
      .cnt       (cnt_all[r]),
      .nz        (nz_v[r]),
      .sat       (sat_v[r]),
      .underflow (uf_v[r])
    );
  end

  // Hazards look only at registered counts; a same-cycle writeback does not release the stall
  always_comb begin
    raw     = (sb.D_use_rs1_i & (sb.D_rs1_i != '0) & nz_v[sb.D_rs1_i]) |
              (sb.D_use_rs2_i & (sb.D_rs2_i != '0) & nz_v[sb.D_rs2_i]);
    sat_hit = sb.D_need_dstE_i & (sb.D_dstE_i != '0) & sat_v[sb.D_dstE_i];
    stall   = sb.D_valid_i & (raw | sat_hit | (state != SB_IDLE) | drain_req_i);
    issue   = sb.D_valid_i & ~stall;
  end

  assign all_zero     = ~|cnt_all;
  assign sb.D_stall_o = stall;
  assign sb.D_issue_o = issue;
  assign busy_o       = nz_v;
  assign drain_done_o = (state == SB_DONE);
  assign sb_err_o     = sb_err_q;

  // Drain FSM: DONE lasts exactly one cycle, giving the single-cycle completion pulse
  always_ff @(posedge clk_i) begin
    if (rst) begin
      state <= SB_IDLE;
    end else begin
      case (state)
        SB_IDLE:  if (drain_req_i) state <= SB_DRAIN;
        SB_DRAIN: begin
          if (!drain_req_i)  state <= SB_IDLE;
          else if (all_zero) state <= SB_DONE;
        end
        SB_DONE:  state <= SB_IDLE;
        default:  state <= SB_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst) begin
      sb_err_q <= 1'b0;
    end else if (|uf_v) begin
      sb_err_q <= 1'b1;
    end
  end
endmodule

// File: tb/tb_reg_scoreboard.sv
// Directed bench for reg_scoreboard: hazards, x0, saturation, flush, drain and reset-abort.
module tb_reg_scoreboard;
  import reg_scoreboard_pkg::*;

  logic        clk_i = 1'b0;
  logic        rst;
  logic        flush_i;
  logic        drain_req_i;
  logic        drain_done_o;
  logic [31:0] busy_o;
  logic        sb_err_o;
  int          checks   = 0;
  int          failures = 0;

  reg_scoreboard_if sb ();

  reg_scoreboard dut (
    .clk_i        (clk_i),
    .rst          (rst),
    .sb           (sb),
    .flush_i      (flush_i),
    .drain_req_i  (drain_req_i),
    .drain_done_o (drain_done_o),
    .busy_o       (busy_o),
    .sb_err_o     (sb_err_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic quiet();
    sb.D_valid_i      = 1'b0;
    sb.D_rs1_i        = '0;
    sb.D_use_rs1_i    = 1'b0;
    sb.D_rs2_i        = '0;
    sb.D_use_rs2_i    = 1'b0;
    sb.D_need_dstE_i  = 1'b0;
    sb.D_dstE_i       = '0;
    sb.MD_need_dstE_i = 1'b0;
    sb.MD_dstE_i      = '0;
    flush_i           = 1'b0;
  endtask

  task automatic writer(input logic [4:0] rd);
    quiet();
    sb.D_valid_i     = 1'b1;
    sb.D_need_dstE_i = 1'b1;
    sb.D_dstE_i      = rd;
  endtask

  task automatic wb(input logic [4:0] rd);
    sb.MD_need_dstE_i = 1'b1;
    sb.MD_dstE_i      = rd;
  endtask

  initial begin
    #20000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    quiet();
    drain_req_i = 1'b0;
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    #1;
    chk("rst_busy", busy_o, 32'h0);
    chk("rst_err", 32'(sb_err_o), 32'h0);
    chk("rst_done", 32'(drain_done_o), 32'h0);
    chk("rst_stall_idle", 32'(sb.D_stall_o), 32'h0);

    // RAW on x5
    writer(5'd5);
    #1 chk("x5_issue", 32'(sb.D_issue_o), 32'h1);
    tick();
    chk("x5_busy", busy_o, 32'h0000_0020);
    quiet();
    sb.D_valid_i = 1'b1; sb.D_use_rs1_i = 1'b1; sb.D_rs1_i = 5'd5;
    #1 chk("x5_raw_stall", 32'(sb.D_stall_o), 32'h1);
    tick();
    chk("x5_raw_stall2", 32'(sb.D_stall_o), 32'h1);
    wb(5'd5);
    #1 chk("x5_no_bypass", 32'(sb.D_stall_o), 32'h1);
    tick();
    sb.MD_need_dstE_i = 1'b0;
    #1 chk("x5_released", 32'(sb.D_stall_o), 32'h0);
    chk("x5_issue_after", 32'(sb.D_issue_o), 32'h1);
    chk("x5_idle_busy", busy_o, 32'h0);

    // x0 never tracked
    writer(5'd0);
    #1 chk("x0_issue", 32'(sb.D_issue_o), 32'h1);
    tick();
    chk("x0_busy", busy_o, 32'h0);
    quiet();
    sb.D_valid_i = 1'b1; sb.D_use_rs1_i = 1'b1; sb.D_use_rs2_i = 1'b1;
    wb(5'd0);
    #1 chk("x0_no_stall", 32'(sb.D_stall_o), 32'h0);
    tick();
    chk("x0_wb_no_err", 32'(sb_err_o), 32'h0);

    // Saturation on x7 (max 3 in flight)
    writer(5'd7);
    for (int i = 0; i < 3; i++) begin
      #1 chk("x7_fill_issue", 32'(sb.D_issue_o), 32'h1);
      tick();
    end
    chk("x7_sat_stall", 32'(sb.D_stall_o), 32'h1);
    wb(5'd7);
    #1 chk("x7_sat_wb_same", 32'(sb.D_stall_o), 32'h1);
    tick();
    sb.MD_need_dstE_i = 1'b0;
    #1 chk("x7_after_wb_issue", 32'(sb.D_issue_o), 32'h1);
    tick();
    chk("x7_resat_stall", 32'(sb.D_stall_o), 32'h1);
    quiet();
    flush_i = 1'b1;
    tick();
    flush_i = 1'b0;
    chk("x7_flushed", busy_o, 32'h0);

    // Concurrent issue and writeback on x9 with count 1
    writer(5'd9);
    tick();
    wb(5'd9);
    #1 chk("x9_both_issue", 32'(sb.D_issue_o), 32'h1);
    tick();
    quiet();
    #1 chk("x9_still_busy", busy_o, 32'h0000_0200);
    wb(5'd9);
    tick();
    quiet();
    chk("x9_one_wb_clears", busy_o, 32'h0);
    chk("x9_no_err", 32'(sb_err_o), 32'h0);

    // Flush with x3=2, x4=1; same-cycle issue/writeback ignored
    writer(5'd3); tick();
    writer(5'd3); tick();
    writer(5'd4); tick();
    quiet();
    chk("flush_pre_busy", busy_o, 32'h0000_0018);
    writer(5'd10);
    wb(5'd4);
    flush_i = 1'b1;
    tick();
    quiet();
    chk("flush_busy", busy_o, 32'h0);
    chk("flush_no_err", 32'(sb_err_o), 32'h0);
    wb(5'd3);
    tick();
    quiet();
    chk("underflow_err", 32'(sb_err_o), 32'h1);
    tick();
    chk("err_sticky", 32'(sb_err_o), 32'h1);

    // Drain with x6 pending
    writer(5'd6);
    tick();
    quiet();
    sb.D_valid_i = 1'b1;
    drain_req_i = 1'b1;
    #1 chk("drain_req_stall", 32'(sb.D_stall_o), 32'h1);
    tick();
    chk("drain_wait_stall", 32'(sb.D_stall_o), 32'h1);
    chk("drain_wait_done", 32'(drain_done_o), 32'h0);
    tick();
    chk("drain_wait_done2", 32'(drain_done_o), 32'h0);
    wb(5'd6);
    tick();
    sb.MD_need_dstE_i = 1'b0;
    #1 chk("drain_wb1_done", 32'(drain_done_o), 32'h0);
    chk("drain_wb1_stall", 32'(sb.D_stall_o), 32'h1);
    tick();
    chk("drain_pulse", 32'(drain_done_o), 32'h1);
    chk("drain_pulse_stall", 32'(sb.D_stall_o), 32'h1);
    drain_req_i = 1'b0;
    tick();
    chk("drain_pulse_end", 32'(drain_done_o), 32'h0);
    chk("drain_reissue", 32'(sb.D_issue_o), 32'h1);

    // Drain with nothing pending: one DRAIN cycle, then pulse
    quiet();
    drain_req_i = 1'b1;
    tick();
    chk("empty_drain_nopulse", 32'(drain_done_o), 32'h0);
    tick();
    chk("empty_drain_pulse", 32'(drain_done_o), 32'h1);
    drain_req_i = 1'b0;
    tick();

    // Abort by deasserting the request: no pulse
    writer(5'd6);
    tick();
    quiet();
    drain_req_i = 1'b1;
    tick();
    tick();
    drain_req_i = 1'b0;
    tick();
    wb(5'd6);
    tick();
    quiet();
    chk("abort_nopulse", 32'(drain_done_o), 32'h0);
    tick();
    chk("abort_nopulse2", 32'(drain_done_o), 32'h0);

    // Reset mid-drain
    writer(5'd6);
    tick();
    quiet();
    drain_req_i = 1'b1;
    tick();
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    drain_req_i = 1'b0;
    sb.D_valid_i = 1'b1;
    #1 chk("rstdrain_busy", busy_o, 32'h0);
    chk("rstdrain_err", 32'(sb_err_o), 32'h0);
    chk("rstdrain_done", 32'(drain_done_o), 32'h0);
    chk("rstdrain_stall", 32'(sb.D_stall_o), 32'h0);
    tick();
    chk("rstdrain_nopulse", 32'(drain_done_o), 32'h0);
    tick();
    chk("rstdrain_nopulse2", 32'(drain_done_o), 32'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
